// File: rtl/led_status.sv
// led_status: synchronised per-channel LED indicators, 1 ms tick and heartbeat.
// Optional PWM dimming of the LED bank when LED_DIM_EN is defined.
module led_status #(
  parameter int CLKRATE    = 12_000_000,
  parameter int BLINK_HZ   = 1,
  parameter int CHANNELS   = 4,
  parameter int STRETCH_MS = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   activity,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [7:0]            brightness,
  output logic                  blink,
  output logic                  ms_tick,
  output logic [CHANNELS-1:0]   led
);

  localparam int PS_DIV = CLKRATE / 1000;
  localparam int PS_W   = (PS_DIV > 1) ? $clog2(PS_DIV) : 1;
  localparam int HB_DIV = 500 / BLINK_HZ;
  localparam int HB_W   = $clog2(HB_DIV) + 1;

  logic [PS_W-1:0]     ps_cnt;
  logic                ps_wrap;
  logic [HB_W-1:0]     hb_cnt;
  logic                hb_wrap;
  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] s3;
  logic [CHANNELS-1:0] edg;
  logic [7:0]          st_cnt [CHANNELS];
  logic [CHANNELS-1:0] raw;

  assign ps_wrap = (ps_cnt == PS_W'(PS_DIV - 1));
  assign hb_wrap = (hb_cnt == HB_W'(HB_DIV - 1));
  assign edg     = s2 ^ s3;

  // ms prescaler; ms_tick is the registered wrap condition
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt  <= '0;
      ms_tick <= 1'b0;
    end else begin
      ms_tick <= ps_wrap;
      ps_cnt  <= ps_wrap ? '0 : ps_cnt + 1'b1;
    end
  end

  // heartbeat: toggle blink every HB_DIV milliseconds
  always_ff @(posedge clk) begin
    if (reset) begin
      hb_cnt <= '0;
      blink  <= 1'b0;
    end else if (ps_wrap) begin
      if (hb_wrap) begin
        hb_cnt <= '0;
        blink  <= ~blink;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // two-stage synchroniser plus previous-sample register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= activity;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // stretch counters: edge reloads, otherwise saturating ms countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++)
        st_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (edg[i])
          st_cnt[i] <= 8'(STRETCH_MS);
        else if (ps_wrap && st_cnt[i] != 8'd0)
          st_cnt[i] <= st_cnt[i] - 8'd1;
      end
    end
  end

  // per-channel mode selection of the undimmed LED value
  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (mode[2*i +: 2])
        2'b00:   raw[i] = s2[i];
        2'b01:   raw[i] = edg[i] | (st_cnt[i] != 8'd0);
        2'b10:   raw[i] = ~s2[i];
        default: raw[i] = 1'b0;
      endcase
    end
  end

`ifdef LED_DIM_EN
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  assign pwm_on = (pwm_cnt < brightness);

  // free-running PWM phase counter
  always_ff @(posedge clk) begin
    if (reset)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + 8'd1;
  end

  // LED register gated by the PWM duty
  always_ff @(posedge clk) begin
    if (reset)
      led <= '0;
    else
      led <= raw & {CHANNELS{pwm_on}};
  end
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;

  // LED register
  always_ff @(posedge clk) begin
    if (reset)
      led <= '0;
    else
      led <= raw;
  end
`endif

endmodule
